// File: rtl/tm1638_pkg.sv
// Shared state encoding and command-byte field definitions for the
// TM1638-style serial display responder.
package tm1638_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    DATA   = 2'd2,
    KEY_TX = 2'd3
  } state_t;

  // Command class lives in bits [7:6] of the first byte after stb falls
  localparam logic [1:0] CMD_DATA = 2'b01;
  localparam logic [1:0] CMD_CTRL = 2'b10;
  localparam logic [1:0] CMD_ADDR = 2'b11;

  localparam int FIXED_ADDR_BIT = 2;
  localparam int READ_KEY_BIT   = 1;
  localparam int DISP_ON_BIT    = 3;

  localparam int KEY_BITS = 32;

endpackage

// File: rtl/tm1638_rx_serial_sync_edge.sv
// Multi-flop synchroniser for one asynchronous serial line, with
// single-cycle rise/fall pulses derived from the synchronised level.
module serial_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Reset to the line's idle level so that leaving reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RESET_VAL}};
      prev  <= RESET_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/tm1638_rx.sv
// Display-driver end of the stb/clk/dio link: decodes commands, holds the
// display RAM and control state, and shifts key-scan data back to the master.
module tm1638_rx
  import tm1638_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 16
) (
  input  logic        _50MHz_CLK,
  input  logic        RST_N,
  input  logic        clk,
  input  logic        stb,
  input  logic        dio,
  output logic        dio_out,
  output logic        dio_oe,
  input  logic [31:0] key_data,
  input  logic [3:0]  rd_addr,
  output logic [7:0]  rd_data,
  output logic        disp_on,
  output logic [2:0]  brightness,
  output logic        frame_done,
  output logic        cmd_err
);

  localparam logic [3:0] ADDR_MASK = 4'(NUM_REGS - 1);

  logic clk_lvl, clk_rise, clk_fall;
  logic stb_lvl, stb_rise, stb_fall;
  logic dio_lvl, dio_rise, dio_fall;
  logic unused_sync;

  state_t      state, state_next;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic [7:0]  full_byte;
  logic        byte_done;
  logic        cmd_taken;
  logic        fixed_mode;
  logic [3:0]  addr;
  logic [7:0]  ram [NUM_REGS];
  logic [31:0] tx_shift;
  logic [5:0]  tx_cnt;
  logic        tx_done;

  logic ram_we, addr_load, mode_load, ctrl_load, key_load;
  logic cmd_err_next, frame_done_next;

  serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk   (_50MHz_CLK),
    .rst_n (RST_N),
    .din   (clk),
    .level (clk_lvl),
    .rise  (clk_rise),
    .fall  (clk_fall)
  );

  serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_stb_sync (
    .clk   (_50MHz_CLK),
    .rst_n (RST_N),
    .din   (stb),
    .level (stb_lvl),
    .rise  (stb_rise),
    .fall  (stb_fall)
  );

  serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_dio_sync (
    .clk   (_50MHz_CLK),
    .rst_n (RST_N),
    .din   (dio),
    .level (dio_lvl),
    .rise  (dio_rise),
    .fall  (dio_fall)
  );

  assign unused_sync = ^{clk_lvl, stb_lvl, dio_rise, dio_fall};

  // dio passes through the same synchroniser depth as clk, so its level is
  // aligned with the detected clk rising edge
  assign full_byte = {dio_lvl, shift_reg[7:1]};
  assign byte_done = clk_rise && (bit_cnt == 3'd7) &&
                     ((state == CMD) || (state == DATA));

  always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // stb edges outrank everything, including a clk edge seen in the same cycle
  always_comb begin
    state_next      = state;
    ram_we          = 1'b0;
    addr_load       = 1'b0;
    mode_load       = 1'b0;
    ctrl_load       = 1'b0;
    key_load        = 1'b0;
    cmd_err_next    = 1'b0;
    frame_done_next = 1'b0;
    if (stb_rise) begin
      state_next      = IDLE;
      frame_done_next = (state != IDLE);
    end else if (stb_fall) begin
      state_next = CMD;
    end else if (byte_done) begin
      case (state)
        CMD: begin
          if (!cmd_taken) begin
            case (full_byte[7:6])
              CMD_DATA: begin
                mode_load = 1'b1;
                if (full_byte[READ_KEY_BIT]) begin
                  key_load   = 1'b1;
                  state_next = KEY_TX;
                end
              end
              CMD_ADDR: begin
                addr_load  = 1'b1;
                state_next = DATA;
              end
              CMD_CTRL: ctrl_load = 1'b1;
              default:  cmd_err_next = 1'b1;
            endcase
          end
        end
        DATA:    ram_we = 1'b1;
        default: ;
      endcase
    end
  end

  // Receive side: byte assembly, command side effects and display RAM
  always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
    if (!RST_N) begin
      shift_reg  <= 8'h00;
      bit_cnt    <= 3'd0;
      cmd_taken  <= 1'b0;
      fixed_mode <= 1'b0;
      addr       <= 4'd0;
      disp_on    <= 1'b0;
      brightness <= 3'd0;
      frame_done <= 1'b0;
      cmd_err    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) ram[i] <= 8'h00;
    end else begin
      frame_done <= frame_done_next;
      cmd_err    <= cmd_err_next;

      if (stb_rise || stb_fall) begin
        bit_cnt <= 3'd0;
      end else if (clk_rise && ((state == CMD) || (state == DATA))) begin
        shift_reg <= full_byte;
        bit_cnt   <= bit_cnt + 3'd1;
      end

      if (stb_rise || stb_fall) cmd_taken <= 1'b0;
      else if (byte_done && (state == CMD)) cmd_taken <= 1'b1;

      if (mode_load) fixed_mode <= full_byte[FIXED_ADDR_BIT];

      if (ctrl_load) begin
        disp_on    <= full_byte[DISP_ON_BIT];
        brightness <= full_byte[2:0];
      end

      if (addr_load) begin
        addr <= full_byte[3:0] & ADDR_MASK;
      end else if (ram_we) begin
        ram[addr] <= full_byte;
        if (!fixed_mode) addr <= (addr + 4'd1) & ADDR_MASK;
      end
    end
  end

  // Transmit side: the first falling edge presents bit 0 without shifting;
  // tx_cnt counts bits already presented
  always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_shift <= 32'h0;
      tx_cnt   <= 6'd0;
      tx_done  <= 1'b0;
      dio_out  <= 1'b1;
    end else begin
      if (key_load) begin
        tx_shift <= key_data;
        tx_cnt   <= 6'd0;
        tx_done  <= 1'b0;
      end else if ((state == KEY_TX) && !tx_done) begin
        if (clk_fall && (tx_cnt < 6'(KEY_BITS))) begin
          if (tx_cnt != 6'd0) tx_shift <= tx_shift >> 1;
          tx_cnt <= tx_cnt + 6'd1;
        end else if (clk_rise && (tx_cnt == 6'(KEY_BITS))) begin
          tx_done <= 1'b1;
        end
      end

      if ((state == KEY_TX) && !tx_done && (tx_cnt != 6'd0)) dio_out <= tx_shift[0];
      else                                                  dio_out <= 1'b1;
    end
  end

  assign dio_oe  = (state == KEY_TX) && !tx_done;
  assign rd_data = ram[rd_addr & ADDR_MASK];

endmodule

// File: doc/tm1638_rx.md
# tm1638_rx

Serial responder for the three-wire display link (stb, clk, dio) driven by the clock/display controller: the display-driver end of that interface, implemented in RTL. It decodes command bytes from the controller, holds the 16-byte display RAM and display-control state, and returns key-scan data on dio for read commands. It runs on the board's 50 MHz clock and oversamples the serial lines, so it drops in beside the controller for loopback checking, or in front of a display model.

## Interface
- SYNC_STAGES, 2, synchroniser depth on clk/stb/dio inputs (≥2)
- NUM_REGS, 16, display RAM depth in bytes (power of two, ≤16)

Ports:
- _50MHz_CLK  in  1  system clock; the only clock
- RST_N  in  1  asynchronous, active-low reset
- clk  in  1  serial clock from controller (asynchronous)
- stb  in  1  strobe from controller, active low (asynchronous)
- dio  in  1  serial data from controller (asynchronous)
- dio_out  out  1  serial data to controller
- dio_oe  out  1  drive enable for dio_out (1 = responder drives the pad)
- key_data  in  32  key-scan word; byte 0 = bits [7:0]
- rd_addr  in  4  display RAM read address
- rd_data  out  8  display RAM byte at rd_addr (combinational read)
- disp_on  out  1  display enable
- brightness  out  3  pulse-width setting
- frame_done  out  1  one-cycle pulse on each stb rising edge that closes a transaction
- cmd_err  out  1  one-cycle pulse on an unrecognised command byte

## Operation
- Serial lines pass through SYNC_STAGES flops, then edge detect.
- Bits are sampled on clk rising edges, LSB first. An 8-bit shift register and a 3-bit counter assemble each byte.
- stb falling: enter CMD, clear the bit counter.
- stb rising: return to IDLE, discard any partial byte, release dio_oe, pulse frame_done.
- FSM states:
  - IDLE: wait for stb low.
  - CMD: decode the first complete byte by bits [7:6].
  - DATA: each further byte writes RAM at addr.
  - KEY_TX: shift key_data out on dio.
- Command 01 (data set): bit2 = fixed address (1) or auto-increment (0), stored as mode. bit1 = 1 latches key_data and enters KEY_TX; bit1 = 0 stays in CMD, so later bytes are ignored until stb rises.
- Command 11 (address set): addr = byte[3:0] mod NUM_REGS; go to DATA.
- Command 10 (display control): disp_on = bit3, brightness = bits[2:0]; stay in CMD, so further bytes are ignored.
- Command 00: pulse cmd_err and ignore the rest of the transaction.
- DATA: after each write, addr increments (wrapping NUM_REGS-1 to 0) unless mode is fixed. Bytes beyond the RAM are not rejected; they wrap.
- KEY_TX: dio_oe = 1. On each clk falling edge, dio_out presents the next bit, LSB of byte 0 first, 32 bits total. After bit 31 has been presented and the following clk rising edge arrives, dio_oe = 0 and dio_out = 1; further clocks are ignored.

## Timing
- Reset values: RAM all 0x00, addr 0, mode auto-increment, disp_on 0, brightness 0, dio_oe 0, dio_out 1, frame_done 0, cmd_err 0, state IDLE.
- Input-to-action latency: SYNC_STAGES+1 system cycles after the pad edge.
- A RAM write, mode or display-control update, or cmd_err is registered one cycle after the detected 8th rising edge.
- key_data is captured in the same cycle the read command completes.
- dio_out changes SYNC_STAGES+2 cycles after a clk falling pad edge.
- Serial clk high and low phases must each last ≥ SYNC_STAGES+2 system cycles. Shorter pulses are unsupported and unchecked.
- stb rising detected in the same cycle as a clk rising edge: stb wins, and that bit is not shifted.
- stb falling while not in IDLE (no rising edge seen): treat as a new transaction start.
- RST_N assertion mid-transaction: all state returns to reset values immediately; dio_oe drops asynchronously.

## Structure
- Shared package tm1638_pkg holds:
  - state enum (IDLE, CMD, DATA, KEY_TX);
  - command-class constants CMD_DATA = 2'b01, CMD_CTRL = 2'b10, CMD_ADDR = 2'b11;
  - bit positions for fixed-address, read-key and display-on.
- One sub-module, serial_sync_edge: a parameterised synchroniser plus rise/fall pulse generator, instanced for clk, stb and dio.

## Test plan
- stb low, 0x40, stb high; stb low, 0xC0, bytes 0x3F, 0x06, 0x5B, stb high → RAM[0..2] = 3F, 06, 5B; addr = 3; frame_done pulses twice.
- 0x44 (fixed address) then 0xC5 and bytes 0x11, 0x22 → RAM[5] = 0x22; RAM[6] unchanged at 0x00.
- 0xC0 + 17 data bytes, 0x01..0x11 (auto-increment) → RAM[0] = 0x11 (wrapped); RAM[1..15] = 0x02..0x10.
- 0x8F → disp_on = 1, brightness = 7; then 0x80 → disp_on = 0, brightness = 0.
- key_data = 0xA5C3_0F81, command 0x42, 32 clocks → master samples 0xA5C30F81, LSB first; dio_oe high only during the 32 bits.
- stb rising after 4 bits of a data byte → no RAM write. A separate transaction with command byte 0x00 → cmd_err pulse, no state change. RST_N low mid-KEY_TX → dio_oe = 0 immediately and all reset values restored.
